display_update_ctrl: RTL
========================

# display_update_ctrl

Sequencing controller that feeds the four-digit seven-segment scanner in the whack-a-mole design. It accepts binary score and time-remaining values from game logic via a request/acknowledge handshake. It converts both values to two-digit packed BCD with a multi-cycle shift-and-add-3 sequence and holds the results on stable output registers for the scanner. It also generates the blanking control that makes the display blink while the game-over condition is active.

## Interface
- VAL_W, 7: width of each binary input value.
- SAT_MAX, 99: saturation ceiling applied before conversion.

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- score_bin  in  VAL_W  binary score; sampled only on request acceptance.
- time_bin  in  VAL_W  binary seconds remaining; sampled only on request acceptance.
- upd_req  in  1  level or pulse; asks for a display refresh.
- upd_ack  out  1  one-cycle pulse; new BCD values are present on the outputs.
- busy  out  1  high while a conversion is in flight.
- game_over  in  1  enables blink mode.
- blink_tick  in  1  one-cycle pulse (nominally 2 Hz) that toggles blink phase.
- left_value  out  8  packed BCD score: [7:4] tens, [3:0] ones.
- right_value  out  8  packed BCD time: [7:4] tens, [3:0] ones.
- blank  out  1  scanner must drive all anodes off while high.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Entry condition: upd_req=1 or pend=1.
  - Latch min(score_bin, SAT_MAX) and min(time_bin, SAT_MAX) into the shift operands.
  - Clear the BCD accumulators and the step counter, clear pend, go to SHIFT.
- SHIFT, one step per cycle for both operands in parallel:
  - Add 3 to any BCD nibble that is ≥5.
  - Shift {bcd, operand} left by 1.
  - Increment the step counter.
  - After step VAL_W (7), go to DONE.
- DONE:
  - Copy the accumulators to left_value and right_value.
  - Assert upd_ack for one cycle and return to IDLE.
- Pending request: upd_req=1 while busy sets pend. This is one-deep; further requests merge into it. The pending conversion samples the inputs at its own acceptance edge, not at request time.
- busy = (state != IDLE).
- Outputs hold their last converted values between updates. There is no intermediate glitching.
- Blink phase:
  - Toggles on each blink_tick while game_over=1.
  - Forced to 0 whenever game_over=0.
  - blank = game_over & phase, registered.
- Reset values:
  - left_value=8'h00, right_value=8'h00.
  - upd_ack=0, busy=0, blank=0.
  - pend=0, phase=0, state=IDLE.
- Reset mid-conversion aborts the conversion. No upd_ack is issued and the outputs return to 8'h00.

## Timing
- Acceptance edge E0: state IDLE with a request present.
- Shift steps occur at E1–E7. The DONE edge E8 updates the outputs and asserts upd_ack.
- After E8:
  - upd_ack=1 and busy=0 in the same cycle.
  - New values are visible on left_value and right_value.
- Latency is 8 cycles from acceptance to outputs valid. Throughput is one conversion per 9 cycles.
- Pending request: acceptance occurs at E9, the first IDLE edge after E8.
- A request held high continuously restarts a conversion every 9 cycles.
- blink_tick coincident with game_over rising: phase toggles to 1 at that edge, and blank=1 in the next cycle.
- game_over falling: blank=0 in the next cycle regardless of blink_tick.
- Blink and conversion are independent. blink_tick during SHIFT is honoured.

## Structure
- Shared package display_pkg holds:
  - the state enum {IDLE, SHIFT, DONE};
  - the BCD nibble width constant (4);
  - SAT_MAX;
  - the blank-all anode constant 4'b1111, for use by the scanner.
- One sub-module, bcd_shift_step: a combinational single double-dabble step (add-3 correction plus shift) over an 8-bit BCD field and a VAL_W operand. It is instantiated twice, for score and time.

## Test plan
- Reset, then score_bin=57, time_bin=30, and a 1-cycle upd_req: upd_ack appears 9 cycles after request assertion (8 edges after acceptance); left_value=8'h57, right_value=8'h30; busy is high for exactly 8 cycles.
- Saturation and zero: score_bin=120, time_bin=0 -> left_value=8'h99, right_value=8'h00.
- Coalesced requests: two pulses during busy with the inputs changed to 12/5 -> exactly one extra conversion starting at E9; the second upd_ack shows 8'h12/8'h05; no third conversion occurs.
- Blink: game_over=1 with blink_tick every 4 cycles -> blank alternates 1,0,1 one cycle after each tick; dropping game_over forces blank=0 next cycle.
- Reset mid-operation: assert rst at E4 of a conversion -> no upd_ack, outputs 8'h00, busy=0, pend=0; a fresh request then completes normally.
- Exhaustive sweep: all inputs 0–127 -> every result matches the saturated decimal value in BCD.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display path.
// Holds the update controller state encoding, BCD field widths,
// the saturation ceiling and the scanner's all-anodes-off pattern.
package display_pkg;

  // Width of one packed BCD digit and of a two-digit field.
  localparam int unsigned BCD_NIB_W = 4;
  localparam int unsigned BCD_W     = 2 * BCD_NIB_W;

  // Largest value representable in two decimal digits.
  localparam int unsigned SAT_MAX = 99;

  // Anode pattern that turns every digit off. The anodes are active-low.
  localparam logic [3:0] ANODE_BLANK_ALL = 4'b1111;

  // Update controller sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } upd_state_e;

  // Two-digit packed BCD value: tens in the upper nibble.
  typedef struct packed {
    logic [BCD_NIB_W-1:0] tens;
    logic [BCD_NIB_W-1:0] ones;
  } bcd2_t;

endpackage

// File: rtl/bcd_shift_step.sv
// One combinational double-dabble step over a two-digit BCD field.
// Ports:
//   bcd_i    - current BCD accumulator (tens in [7:4], ones in [3:0])
//   opnd_i   - remaining binary operand, MSB is shifted into the BCD field
//   bcd_c_o  - accumulator after add-3 correction and left shift
//   opnd_c_o - operand after left shift
module bcd_shift_step
  import display_pkg::*;
#(
  parameter int unsigned VAL_W = 7
) (
  input  logic [BCD_W-1:0] bcd_i,
  input  logic [VAL_W-1:0] opnd_i,
  output logic [BCD_W-1:0] bcd_c_o,
  output logic [VAL_W-1:0] opnd_c_o
);

  logic [BCD_W-1:0] adj;

  // Add 3 to any digit of 5 or more so that the doubling carries into the next decade.
  always_comb begin
    adj = bcd_i;
    if (bcd_i[BCD_NIB_W-1:0] >= BCD_NIB_W'(5)) begin
      adj[BCD_NIB_W-1:0] = bcd_i[BCD_NIB_W-1:0] + BCD_NIB_W'(3);
    end
    if (bcd_i[BCD_W-1:BCD_NIB_W] >= BCD_NIB_W'(5)) begin
      adj[BCD_W-1:BCD_NIB_W] = bcd_i[BCD_W-1:BCD_NIB_W] + BCD_NIB_W'(3);
    end
  end

  // Shift {bcd, operand} left by one. The bit leaving the top of the field is
  // always zero for inputs up to 99, so the truncation is safe.
  assign bcd_c_o  = BCD_W'({adj, opnd_i[VAL_W-1]});
  assign opnd_c_o = {opnd_i[VAL_W-2:0], 1'b0};

endmodule

// File: rtl/display_update_ctrl.sv
// Display update controller for the four-digit seven-segment scanner.
// It accepts score and time values on request, saturates them to two decimal
// digits and converts them to packed BCD over several cycles. It holds the
// results steady for the scanner and generates the game-over blink blanking.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   score_bin         - binary score, sampled when a request is accepted
//   time_bin          - binary seconds remaining, sampled when a request is accepted
//   upd_req           - refresh request (level or pulse)
//   upd_ack           - one-cycle pulse when new BCD values are presented
//   busy              - a conversion is in flight
//   game_over         - enables blink mode
//   blink_tick        - one-cycle pulse that toggles the blink phase
//   left_value        - packed BCD score
//   right_value       - packed BCD time
//   blank             - scanner turns all anodes off while high
module display_update_ctrl #(
  parameter int unsigned VAL_W   = 7,
  parameter int unsigned SAT_MAX = display_pkg::SAT_MAX
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [VAL_W-1:0]                score_bin,
  input  logic [VAL_W-1:0]                time_bin,
  input  logic                            upd_req,
  output logic                            upd_ack,
  output logic                            busy,
  input  logic                            game_over,
  input  logic                            blink_tick,
  output logic [display_pkg::BCD_W-1:0]   left_value,
  output logic [display_pkg::BCD_W-1:0]   right_value,
  output logic                            blank
);

  import display_pkg::*;

  localparam int unsigned STEP_W = $clog2(VAL_W + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(VAL_W - 1);
  localparam logic [VAL_W-1:0]  SAT_VAL   = VAL_W'(SAT_MAX);

  upd_state_e         state_q,    state_d;
  logic [VAL_W-1:0]   score_op_q, score_op_d;
  logic [VAL_W-1:0]   time_op_q,  time_op_d;
  bcd2_t              score_bcd_q, score_bcd_d;
  bcd2_t              time_bcd_q,  time_bcd_d;
  logic [STEP_W-1:0]  step_q,     step_d;
  logic               pend_q,     pend_d;
  logic               phase_q,    phase_d;
  logic               blank_q,    blank_d;
  logic               upd_ack_q,  upd_ack_d;
  logic               busy_q,     busy_d;
  bcd2_t              left_q,     left_d;
  bcd2_t              right_q,    right_d;

  logic [VAL_W-1:0]   score_sat_c;
  logic [VAL_W-1:0]   time_sat_c;
  logic [BCD_W-1:0]   score_bcd_step_c;
  logic [BCD_W-1:0]   time_bcd_step_c;
  logic [VAL_W-1:0]   score_op_step_c;
  logic [VAL_W-1:0]   time_op_step_c;

  // Clamp inputs to the two-digit range before conversion.
  assign score_sat_c = (score_bin > SAT_VAL) ? SAT_VAL : score_bin;
  assign time_sat_c  = (time_bin  > SAT_VAL) ? SAT_VAL : time_bin;

  // Score and time convert in lock-step.
  bcd_shift_step #(
    .VAL_W (VAL_W)
  ) u_score_step (
    .bcd_i    (score_bcd_q),
    .opnd_i   (score_op_q),
    .bcd_c_o  (score_bcd_step_c),
    .opnd_c_o (score_op_step_c)
  );

  bcd_shift_step #(
    .VAL_W (VAL_W)
  ) u_time_step (
    .bcd_i    (time_bcd_q),
    .opnd_i   (time_op_q),
    .bcd_c_o  (time_bcd_step_c),
    .opnd_c_o (time_op_step_c)
  );

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    score_op_d  = score_op_q;
    time_op_d   = time_op_q;
    score_bcd_d = score_bcd_q;
    time_bcd_d  = time_bcd_q;
    step_d      = step_q;
    pend_d      = pend_q;
    left_d      = left_q;
    right_d     = right_q;
    upd_ack_d   = 1'b0;

    // Requests that arrive mid-conversion merge into a single pending refresh.
    if (upd_req && (state_q != IDLE)) begin
      pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (upd_req || pend_q) begin
          score_op_d  = score_sat_c;
          time_op_d   = time_sat_c;
          score_bcd_d = '0;
          time_bcd_d  = '0;
          step_d      = '0;
          pend_d      = 1'b0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        score_bcd_d = score_bcd_step_c;
        time_bcd_d  = time_bcd_step_c;
        score_op_d  = score_op_step_c;
        time_op_d   = time_op_step_c;
        step_d      = step_q + STEP_W'(1);
        if (step_q == STEP_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        left_d    = score_bcd_q;
        right_d   = time_bcd_q;
        upd_ack_d = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);

    // Blink phase runs only while game over is active and is independent of conversion.
    if (!game_over) begin
      phase_d = 1'b0;
    end else if (blink_tick) begin
      phase_d = ~phase_q;
    end else begin
      phase_d = phase_q;
    end
    blank_d = game_over & phase_d;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      score_op_q  <= '0;
      time_op_q   <= '0;
      score_bcd_q <= '0;
      time_bcd_q  <= '0;
      step_q      <= '0;
      pend_q      <= 1'b0;
      phase_q     <= 1'b0;
      blank_q     <= 1'b0;
      upd_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
    end else begin
      state_q     <= state_d;
      score_op_q  <= score_op_d;
      time_op_q   <= time_op_d;
      score_bcd_q <= score_bcd_d;
      time_bcd_q  <= time_bcd_d;
      step_q      <= step_d;
      pend_q      <= pend_d;
      phase_q     <= phase_d;
      blank_q     <= blank_d;
      upd_ack_q   <= upd_ack_d;
      busy_q      <= busy_d;
      left_q      <= left_d;
      right_q     <= right_d;
    end
  end

  assign upd_ack     = upd_ack_q;
  assign busy        = busy_q;
  assign blank       = blank_q;
  assign left_value  = left_q;
  assign right_value = right_q;

endmodule
